alu_seq_core: RTL
=================

# alu_seq_core

Sequential ALU execution core that sits directly downstream of the ALU_ip AXI4-Lite slave register bank. The register bank presents operand A, operand B and an opcode as a command. This block executes the command and returns result, flags and error through a valid/ready response the register bank captures into its read-back registers. Logic/add/shift ops finish in one cycle; MUL/DIVU/REMU run as iterative shift-add/restoring-divide sequences.

## Interface
Parameters:
- C_DATA_WIDTH, 32, operand/result width W (power of 2, ≥8)

Ports:
- ACLK  in  1  clock, all logic rising-edge
- ARESET  in  1  reset, synchronous, active-high
- cmd_valid  in  1  command present
- cmd_ready  out  1  core can accept command
- cmd_op  in  4  opcode
- cmd_a  in  W  operand A
- cmd_b  in  W  operand B
- rsp_valid  out  1  response present
- rsp_ready  in  1  consumer takes response
- rsp_result  out  W  result
- rsp_flags  out  4  {V,C,N,Z}
- rsp_err  out  1  divide-by-zero or illegal opcode
- busy  out  1  state ≠ IDLE

## Operation
- Opcodes: 0 ADD, 1 SUB (A−B), 2 AND, 3 OR, 4 XOR, 5 SLL, 6 SRL, 7 SRA, 8 MUL (low W bits, unsigned), 9 DIVU, 10 REMU; 11–15 illegal.
- Shifts use B[log2(W)−1:0] only.
- FSM IDLE→(accept)→CALC or DONE; CALC→DONE after W steps; DONE→(rsp handshake)→IDLE.
- cmd_ready = (state==IDLE) && !ARESET; accept = cmd_valid && cmd_ready; cmd_* sampled only on accept.
- Single-cycle ops (0–7), illegal ops, and DIVU/REMU with B==0 go straight to DONE.
- MUL/DIVU/REMU with B≠0 enter CALC: step counter 0..W−1, one shift-add or restoring-subtract step per cycle.
- Illegal op: result 0, err 1, flags Z=1, others 0.
- Div by zero: DIVU result all-ones, REMU result = A, err 1.
- Flags: Z = (result==0); N = result[W−1]. ADD: C = carry-out, V = signed overflow. SUB: C = 1 when A ≥ B unsigned (no borrow), V = signed overflow. All other ops: C = V = 0.
- rsp_valid = (state==DONE). rsp_* held stable while rsp_valid && !rsp_ready. No new command is accepted in DONE; a new command is accepted no earlier than the cycle after the response handshake.

## Timing
- Reset (ARESET high at edge): state IDLE, counter 0. rsp_valid 0, rsp_result 0, rsp_flags 0, rsp_err 0, busy 0. cmd_ready forced 0 while ARESET high.
- Reset mid-CALC or in DONE: operation aborted, pending response discarded, next cycle IDLE.
- Latency (accept edge → first edge rsp_valid is sampled high): 1 cycle for single-cycle/error cases; W+1 cycles for iterative ops (W CALC cycles + DONE).
- Throughput: max one command per 2 cycles (single-cycle op with rsp_ready tied high).
- busy asserted from the cycle after accept until the cycle after the response handshake.
- Iterative datapath registered; single-cycle result computed combinationally from captured operands and registered on accept.

## Structure
- Package alu_pkg: op enum (ALU_ADD..ALU_REMU), flag bit index constants (FLAG_Z=0, FLAG_N=1, FLAG_C=2, FLAG_V=3), state enum (ST_IDLE, ST_CALC, ST_DONE).
- Sub-module alu_iter_muldiv: iterative MUL/DIVU/REMU engine with start/step/done, owning the accumulator, quotient and remainder registers and the step counter. The top holds the FSM, single-cycle ops, flag logic and the handshakes.

## Test plan
- ADD A=0xFFFFFFFF, B=1, rsp_ready=1 → result 0x0, flags Z=1 C=1 V=0 N=0, rsp_valid 1 cycle after accept.
- SUB A=0x80000000, B=1 → result 0x7FFFFFFF, V=1, C=1, N=0; SRA A=0x80000000, B=0x24 → shift by 4, result 0xF8000000, N=1.
- MUL A=0x00010003, B=0x00020005 → result 0x000B000F, rsp_valid exactly 33 cycles after accept; cmd_valid held high throughout, no second accept before the response handshake.
- DIVU A=100, B=7 → 14, err 0; REMU A=100, B=7 → 2; DIVU A=5, B=0 → 0xFFFFFFFF, err 1, latency 1.
- Backpressure: rsp_ready=0 for 10 cycles after XOR A=0xF0F0F0F0, B=0xFFFF0000 → result 0x0F0FF0F0 held stable, cmd_ready 0, busy 1; handshake then IDLE. Illegal op 12 → err 1, result 0.
- ARESET pulsed at CALC step 10 of a DIVU → next cycle rsp_valid 0, busy 0, all outputs 0; a fresh ADD 2+3 afterwards returns 5.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared types and constants for the sequential ALU core.
//   alu_op_t     : command opcodes (values 11..15 are illegal)
//   FLAG_*       : bit positions inside the 4-bit {V,C,N,Z} flag vector
//   alu_state_t  : control FSM states of alu_seq_core
//   is_iter_op() : true for opcodes executed by the iterative engine
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_ADD  = 4'd0,
    ALU_SUB  = 4'd1,
    ALU_AND  = 4'd2,
    ALU_OR   = 4'd3,
    ALU_XOR  = 4'd4,
    ALU_SLL  = 4'd5,
    ALU_SRL  = 4'd6,
    ALU_SRA  = 4'd7,
    ALU_MUL  = 4'd8,
    ALU_DIVU = 4'd9,
    ALU_REMU = 4'd10
  } alu_op_t;

  localparam int FLAG_Z = 0;
  localparam int FLAG_N = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_V = 3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CALC = 2'd1,
    ST_DONE = 2'd2
  } alu_state_t;

  function automatic logic is_iter_op(input logic [3:0] op);
    return (op == ALU_MUL) || (op == ALU_DIVU) || (op == ALU_REMU);
  endfunction

endpackage

// File: rtl/alu_iter_muldiv.sv
// alu_iter_muldiv: iterative MUL / DIVU / REMU engine, one bit per step.
//   clk, rst   : clock, synchronous active-high reset
//   start      : load operands a/b and opcode op, clear step counter
//   step       : perform one shift-add (MUL) or restoring-subtract (DIV) step
//   done       : high during the step that completes the W-th iteration
//   result     : MUL low product, DIVU quotient or REMU remainder
// MUL : acc += x when y[0]; x <<= 1; y >>= 1  (x = multiplicand, y = multiplier)
// DIV : {acc,x} shifted left one bit per step; acc holds the partial
//       remainder, x collects quotient bits from the right, y = divisor.
module alu_iter_muldiv
  import alu_pkg::*;
#(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [3:0]   op,
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         step,
  output logic         done,
  output logic [W-1:0] result
);

  localparam int CW = $clog2(W);
  localparam logic [CW-1:0] LAST_STEP = CW'(W - 1);

  logic [W-1:0]  acc_q;
  logic [W-1:0]  x_q;
  logic [W-1:0]  y_q;
  logic [CW-1:0] cnt_q;
  logic          is_mul_q;
  logic          want_rem_q;

  logic [W:0]    rem_sh;
  logic [W:0]    trial;

  // Partial remainder shifted left with the next dividend bit; the trial
  // subtraction is one bit wider so its MSB is the borrow.
  always_comb begin
    rem_sh = {acc_q, x_q[W-1]};
    trial  = rem_sh - {1'b0, y_q};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc_q      <= '0;
      x_q        <= '0;
      y_q        <= '0;
      cnt_q      <= '0;
      is_mul_q   <= 1'b0;
      want_rem_q <= 1'b0;
    end else if (start) begin
      acc_q      <= '0;
      x_q        <= a;
      y_q        <= b;
      cnt_q      <= '0;
      is_mul_q   <= (op == ALU_MUL);
      want_rem_q <= (op == ALU_REMU);
    end else if (step) begin
      cnt_q <= cnt_q + 1'b1;
      if (is_mul_q) begin
        if (y_q[0]) begin
          acc_q <= acc_q + x_q;
        end
        x_q <= x_q << 1;
        y_q <= y_q >> 1;
      end else if (!trial[W]) begin
        acc_q <= trial[W-1:0];
        x_q   <= {x_q[W-2:0], 1'b1};
      end else begin
        acc_q <= rem_sh[W-1:0];
        x_q   <= {x_q[W-2:0], 1'b0};
      end
    end
  end

  assign done   = step && (cnt_q == LAST_STEP);
  assign result = (is_mul_q || want_rem_q) ? acc_q : x_q;

endmodule

// File: rtl/alu_seq_core.sv
// alu_seq_core: sequential ALU execution core.
//   ACLK, ARESET                     : clock, synchronous active-high reset
//   cmd_valid/cmd_ready              : command handshake
//   cmd_op, cmd_a, cmd_b             : opcode and operands, sampled on accept
//   rsp_valid/rsp_ready              : response handshake
//   rsp_result, rsp_flags, rsp_err   : result, {V,C,N,Z}, error
//   busy                             : FSM not in IDLE
// Handshakes: a transfer happens on a rising edge where valid && ready.
// The producer holds valid and payload until that edge; rsp_* are driven
// only while rsp_valid is high and stay stable until the handshake.
// Single-cycle ops are computed from cmd_a/cmd_b and registered on accept;
// MUL/DIVU/REMU with a nonzero divisor run W steps in alu_iter_muldiv.
module alu_seq_core
  import alu_pkg::*;
#(
  parameter int C_DATA_WIDTH = 32
) (
  input  logic                    ACLK,
  input  logic                    ARESET,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              cmd_op,
  input  logic [C_DATA_WIDTH-1:0] cmd_a,
  input  logic [C_DATA_WIDTH-1:0] cmd_b,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [C_DATA_WIDTH-1:0] rsp_result,
  output logic [3:0]              rsp_flags,
  output logic                    rsp_err,
  output logic                    busy
);

  localparam int W   = C_DATA_WIDTH;
  localparam int SHW = $clog2(W);

  alu_state_t state_q;
  alu_state_t state_d;

  logic         accept;
  logic         eng_start;
  logic         eng_step;
  logic         eng_done;
  logic [W-1:0] eng_result;

  // Single-cycle datapath
  logic [W:0]     add_ext;
  logic [W-1:0]   sub_res;
  logic [SHW-1:0] shamt;
  logic [W-1:0]   sc_result;
  logic [3:0]     sc_flags;
  logic           sc_err;
  logic           go_calc;

  // Captured response of a single-cycle / error command
  logic [W-1:0] res_q;
  logic [3:0]   flags_q;
  logic         err_q;
  logic         iter_q;

  always_comb begin
    add_ext   = {1'b0, cmd_a} + {1'b0, cmd_b};
    sub_res   = cmd_a - cmd_b;
    shamt     = cmd_b[SHW-1:0];
    sc_result = '0;
    sc_flags  = '0;
    sc_err    = 1'b0;
    go_calc   = 1'b0;
    case (cmd_op)
      ALU_ADD: begin
        sc_result        = add_ext[W-1:0];
        sc_flags[FLAG_C] = add_ext[W];
        sc_flags[FLAG_V] = (cmd_a[W-1] == cmd_b[W-1]) && (add_ext[W-1] != cmd_a[W-1]);
      end
      ALU_SUB: begin
        sc_result        = sub_res;
        sc_flags[FLAG_C] = (cmd_a >= cmd_b);
        sc_flags[FLAG_V] = (cmd_a[W-1] != cmd_b[W-1]) && (sub_res[W-1] != cmd_a[W-1]);
      end
      ALU_AND: sc_result = cmd_a & cmd_b;
      ALU_OR:  sc_result = cmd_a | cmd_b;
      ALU_XOR: sc_result = cmd_a ^ cmd_b;
      ALU_SLL: sc_result = cmd_a << shamt;
      ALU_SRL: sc_result = cmd_a >> shamt;
      ALU_SRA: sc_result = $unsigned($signed(cmd_a) >>> shamt);
      ALU_MUL: go_calc = 1'b1;
      ALU_DIVU, ALU_REMU: begin
        if (cmd_b == '0) begin
          // Divide by zero completes immediately with a defined result.
          sc_err    = 1'b1;
          sc_result = (cmd_op == ALU_DIVU) ? '1 : cmd_a;
        end else begin
          go_calc = 1'b1;
        end
      end
      default: sc_err = 1'b1;  // illegal opcode: result stays 0
    endcase
    sc_flags[FLAG_Z] = (sc_result == '0);
    sc_flags[FLAG_N] = sc_result[W-1];
  end

  // FSM: state register
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (accept)    state_d = go_calc ? ST_CALC : ST_DONE;
      ST_CALC: if (eng_done)  state_d = ST_DONE;
      ST_DONE: if (rsp_ready) state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    cmd_ready = (state_q == ST_IDLE) && !ARESET;
    accept    = cmd_valid && cmd_ready;
    rsp_valid = (state_q == ST_DONE);
    busy      = (state_q != ST_IDLE);
    eng_start = accept && go_calc;
    eng_step  = (state_q == ST_CALC);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      res_q   <= '0;
      flags_q <= '0;
      err_q   <= 1'b0;
      iter_q  <= 1'b0;
    end else if (accept) begin
      res_q   <= sc_result;
      flags_q <= sc_flags;
      err_q   <= sc_err;
      iter_q  <= go_calc;
    end
  end

  alu_iter_muldiv #(
    .W (W)
  ) u_muldiv (
    .clk    (ACLK),
    .rst    (ARESET),
    .start  (eng_start),
    .op     (cmd_op),
    .a      (cmd_a),
    .b      (cmd_b),
    .step   (eng_step),
    .done   (eng_done),
    .result (eng_result)
  );

  // Response mux. The engine registers are frozen outside CALC, so the
  // iterative result is stable for the whole DONE state. Iterative ops
  // only ever report Z and N.
  always_comb begin
    rsp_result = '0;
    rsp_flags  = '0;
    rsp_err    = 1'b0;
    if (rsp_valid) begin
      if (iter_q) begin
        rsp_result        = eng_result;
        rsp_flags[FLAG_Z] = (eng_result == '0);
        rsp_flags[FLAG_N] = eng_result[W-1];
      end else begin
        rsp_result = res_q;
        rsp_flags  = flags_q;
        rsp_err    = err_q;
      end
    end
  end

endmodule
